// File: rtl/muldiv_ctrl_if.sv
// Handshake and operand bundle between the EX stage and the HI/LO multiply/divide sequencer.
// The master side is the pipeline, and the slave side is the sequencer.
interface muldiv_ctrl_if;
   logic        flush;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        stall;
   logic        busy;
   logic        result_valid;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output flush, start, op, a, b,
      input  stall, busy, result_valid, hi, lo
   );

   modport slave (
      input  flush, start, op, a, b,
      output stall, busy, result_valid, hi, lo
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. It stalls EX while running and returns {hi, lo}.
// Division is a 32-step radix-2 restoring loop on operand magnitudes, with signs fixed up at the end.
module muldiv_ctrl #(
   parameter int MUL_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state, state_nx;
   logic [4:0]  cnt, cnt_nx;

   logic        sgn_q;
   logic [31:0] a_q, b_q;
   logic [31:0] rem, quo, dvs;
   logic [31:0] hi_q, lo_q;

   logic        accept;
   logic        res_en;
   logic [31:0] res_hi, res_lo;

   logic signed [63:0] mul_a, mul_b, prod;

   logic [32:0] rem_sh;
   logic        step_ge;
   logic [31:0] rem_nx, quo_nx;

   function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic c);
      return c ? (~v + 32'd1) : v;
   endfunction

   // One 64-bit multiplier serves both forms: operands are sign- or zero-extended before the multiply.
   assign mul_a = $signed({{32{sgn_q & a_q[31]}}, a_q});
   assign mul_b = $signed({{32{sgn_q & b_q[31]}}, b_q});
   assign prod  = mul_a * mul_b;

   // One restoring step. The remainder stays below the divisor, so the shifted value needs only 33 bits.
   always_comb begin
      rem_sh  = {rem, quo[31]};
      step_ge = (rem_sh >= {1'b0, dvs});
      rem_nx  = step_ge ? 32'(rem_sh - {1'b0, dvs}) : rem_sh[31:0];
      quo_nx  = {quo[30:0], step_ge};
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      res_en   = 1'b0;
      res_hi   = hi_q;
      res_lo   = lo_q;
      unique case (state)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               accept = 1'b1;
               cnt_nx = 5'd0;
               if (!bus.op[1]) begin
                  state_nx = MUL;
               end else if (bus.b != 32'd0) begin
                  state_nx = DIV;
               end else begin
                  state_nx = DONE;
                  res_en   = 1'b1;
                  res_hi   = bus.a;
                  res_lo   = 32'hFFFF_FFFF;
               end
            end
         end
         MUL: begin
            cnt_nx = cnt + 5'd1;
            if (cnt == 5'(MUL_CYCLES - 1)) begin
               state_nx = DONE;
               res_en   = 1'b1;
               res_hi   = prod[63:32];
               res_lo   = prod[31:0];
            end
         end
         DIV: begin
            cnt_nx = cnt + 5'd1;
            if (cnt == 5'd31) begin
               state_nx = DONE;
               res_en   = 1'b1;
               res_hi   = neg_if(rem_nx, sgn_q & a_q[31]);
               res_lo   = neg_if(quo_nx, sgn_q & (a_q[31] ^ b_q[31]));
            end
         end
         DONE: begin
            state_nx = IDLE;
            cnt_nx   = 5'd0;
         end
      endcase
      // A flush cancels any work. It never suppresses the result_valid already showing in DONE.
      if (bus.flush) begin
         state_nx = IDLE;
         cnt_nx   = 5'd0;
         accept   = 1'b0;
         res_en   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 5'd0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (res_en) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end
   end

   // Operand and divider registers are pure datapath. The FSM decides when they are meaningful.
   always_ff @(posedge clk) begin
      if (accept) begin
         sgn_q <= ~bus.op[0];
         a_q   <= bus.a;
         b_q   <= bus.b;
         rem   <= 32'd0;
         quo   <= mag(bus.a, ~bus.op[0]);
         dvs   <= mag(bus.b, ~bus.op[0]);
      end else if (state == DIV) begin
         rem   <= rem_nx;
         quo   <= quo_nx;
      end
   end

   assign bus.stall        = ~bus.flush & (((state == IDLE) & bus.start) | (state == MUL) | (state == DIV));
   assign bus.busy         = (state != IDLE);
   assign bus.result_valid = (state == DONE);
   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller for the multi-cycle HI/LO operations: MULT, MULTU, DIV and DIVU. It accepts one operation from the EX stage and stalls the pipeline while the operation runs. The multiply completes after a fixed count of cycles. The divide runs as a 32-iteration radix-2 restoring loop on operand magnitudes. The block returns a 64-bit {hi, lo} result with a one-cycle valid pulse for HI/LO writeback, and supports cancellation by exception flush.

Parameters:
MUL_CYCLES, 4, cycles spent in MUL state before the result is taken (legal range 1..15)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  exception/cancel; aborts any operation in progress
start  in  1  EX stage holds a mult/div instruction; held high by the pipeline while stalled
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  32  rs operand (multiplicand / dividend)
b  in  32  rt operand (multiplier / divisor)
stall  out  1  pipeline stall request (combinational)
busy  out  1  state is not IDLE (registered)
result_valid  out  1  one-cycle pulse; hi/lo hold a new result
hi  out  32  MULT: product[63:32]; DIV: remainder
lo  out  32  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, counter=0, hi=0, lo=0, result_valid=0, busy=0. Reset overrides flush and start. Reset mid-operation discards all work.
- States are IDLE, MUL, DIV and DONE.
- IDLE:
  - start=1 and flush=0: latch op, a, b.
  - op[1]=0: go to MUL with counter=0.
  - op[1]=1 and b≠0: go to DIV with counter=0, using the magnitudes |a| and |b| for signed DIV and raw values for DIVU.
  - op[1]=1 and b==0: go directly to DONE with lo=32'hFFFFFFFF and hi=a. Operand signedness has no effect on this result.
- MUL:
  - counter increments each cycle.
  - When counter==MUL_CYCLES-1, go to DONE and load hi/lo with the 64-bit product of the latched operands: signed for MULT, unsigned for MULTU.
- DIV:
  - One restoring step per cycle for 32 cycles (counter 0..31).
  - Each step: shift {rem,quo} left 1, trial-subtract |b| from rem, set quotient bit if the result is non-negative.
  - After step 31, go to DONE.
  - hi = remainder, negated if signed and a[31]=1.
  - lo = quotient, negated if signed and a[31]^b[31]=1.
  - Negation is mod 2^32, so 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
- DONE: result_valid=1 for exactly this cycle, then IDLE. start is ignored in DONE; the same instruction retires this cycle.
- stall = ~flush & ( (state==IDLE & start) | state==MUL | state==DIV ). stall is 0 in DONE.
- Latency:
  - MUL: stall high for 1+MUL_CYCLES cycles; result_valid in the following cycle.
  - DIV: stall high for 33 cycles; result_valid on cycle 34.
  - DIV by zero: stall for 1 cycle; result_valid on cycle 2.
- Flush:
  - In any state, flush=1 forces IDLE at the next edge.
  - No result_valid is produced and hi/lo are not updated.
  - stall drops in the same cycle as flush.
  - A flush in DONE still allows the already-asserted result_valid of that cycle. The EX-stage writeback gating owns its cancellation.
- hi/lo change only on entry to DONE, or on reset. Otherwise they hold their value.
- busy = (state != IDLE).
- start arriving while busy (excluding the holding instruction) has no effect.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, MUL_CYCLES=4 -> stall high 5 cycles; result_valid next cycle with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> stall 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=0x12345678, b=0 -> 1 stall cycle; lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started, flush at counter=10 -> stall drops the same cycle; no result_valid; hi/lo keep prior values. A new MULT 6*7 issued next -> hi=0, lo=42.
- rst asserted mid-MUL -> next cycle busy=0, stall=0 (start=0), hi=lo=0, result_valid=0.
